atx_pll_rst_seq: RTL and testbench
==================================

Name: atx_pll_rst_seq

Overview:
Power-up and reset sequencer for the 5G KR ATX transmit PLL and its master CGB. It sits directly upstream of the ATX PLL instance: it drives pll_powerdown and mcgb_rst, and watches pll_cal_busy and pll_locked. It releases tx_clk_ready to the TX PCS reset logic only after a filtered, stable lock. It re-sequences automatically on lock timeout or loss of lock, and on software request.

Parameters:
PWRDN_CYC, 100, cycles pll_powerdown is held asserted in PWRDN (minimum 1)
CAL_MIN_CYC, 8, minimum cycles spent in WAIT_CAL before cal_busy is sampled
LOCK_STABLE_CYC, 1000, consecutive synced-locked cycles required to leave WAIT_LOCK
LOCK_TIMEOUT_CYC, 100000, limit for WAIT_CAL+WAIT_LOCK combined, counted from WAIT_CAL entry
MCGB_RST_CYC, 16, cycles mcgb_rst stays asserted after lock is qualified
LOL_FILT_CYC, 3, consecutive synced-unlocked cycles in READY that count as loss of lock
RETRY_W, 8, width of retry_cnt

Ports:
clk  in  1  free-running system clock; all logic is on this clock
rst_n  in  1  asynchronous active-low reset; deassertion is synchronized externally
restart_req  in  1  single-cycle synchronous request to restart the sequence
pll_locked  in  1  ATX PLL lock; asynchronous to clk, 2-flop synchronized internally
pll_cal_busy  in  1  ATX PLL calibration busy; asynchronous, 2-flop synchronized internally
pll_powerdown  out  1  to ATX PLL powerdown, active high
mcgb_rst  out  1  to master CGB reset, active high
tx_clk_ready  out  1  high when the serial clock is usable by the TX path
lock_timeout  out  1  one-cycle pulse when a lock timeout fires
retry_cnt  out  RETRY_W  saturating count of lock timeouts since reset
fsm_state  out  3  current state encoding, for status registers

Behaviour:
- Reset (rst_n=0, asynchronous): state=PWRDN, pll_powerdown=1, mcgb_rst=1, tx_clk_ready=0, lock_timeout=0, retry_cnt=0, fsm_state=0, all timers and synchronizer flops=0.
- Synchronized signals locked_s and cal_busy_s lag their inputs by 2 clk cycles. All decisions use only these synced signals.
- Outputs are registered and decoded from the next state, so they change in the same cycle fsm_state changes.
- Encoding: PWRDN=0, WAIT_CAL=1, WAIT_LOCK=2, MCGB_RST=3, READY=4. Codes 5-7 return to PWRDN on the next cycle.
- PWRDN: pll_powerdown=1, mcgb_rst=1, tx_clk_ready=0. Stay exactly PWRDN_CYC cycles, then go to WAIT_CAL. The timeout timer clears on this exit.
- WAIT_CAL: pll_powerdown=0, mcgb_rst=1. Once at least CAL_MIN_CYC cycles have elapsed in this state and cal_busy_s=0, go to WAIT_LOCK.
- WAIT_LOCK: pll_powerdown=0, mcgb_rst=1. A stability counter increments while locked_s=1 and clears to 0 whenever locked_s=0. When it reaches LOCK_STABLE_CYC, go to MCGB_RST.
- Timeout: the timeout timer runs in WAIT_CAL and WAIT_LOCK. When it reaches LOCK_TIMEOUT_CYC:
  - go to PWRDN;
  - lock_timeout pulses for 1 cycle;
  - retry_cnt increments and saturates at all-ones.
  - Timeout takes priority over a lock qualification in the same cycle.
- MCGB_RST: pll_powerdown=0, mcgb_rst=1 for MCGB_RST_CYC cycles, then go to READY. If locked_s=0 in any cycle of this state, go to PWRDN without incrementing retry_cnt.
- READY: pll_powerdown=0, mcgb_rst=0, tx_clk_ready=1.
  - A loss-of-lock counter counts consecutive cycles with locked_s=0 and clears on locked_s=1.
  - When it reaches LOL_FILT_CYC, go to PWRDN; tx_clk_ready falls that same cycle. retry_cnt is unchanged.
  - Glitches shorter than LOL_FILT_CYC are ignored.
- restart_req=1 in any state: go to PWRDN next cycle with all timers cleared. It has highest priority; retry_cnt is unchanged and no lock_timeout pulse occurs. A restart while already in PWRDN restarts the PWRDN count.
- cal_busy_s reasserting in WAIT_LOCK is ignored; only lock stability matters.
- Timer widths are sized by $clog2 of the largest parameter + 1. No counter wraps: every counter stops at its terminal value or is cleared by a state change.

Test Plan:
Test parameters: PWRDN_CYC=10, CAL_MIN_CYC=8, LOCK_STABLE_CYC=20, LOCK_TIMEOUT_CYC=200, MCGB_RST_CYC=4, LOL_FILT_CYC=3, RETRY_W=2.
1. Nominal bring-up: release rst_n; cal_busy pulses high for 30 cycles, then locked=1. Required: pll_powerdown falls 10 cycles after reset release. WAIT_LOCK is entered 2 cycles after cal_busy falls. mcgb_rst falls and tx_clk_ready rises 20+4 cycles after locked_s rises.
2. Lock chatter: locked toggles low for 1 cycle every 15 cycles in WAIT_LOCK. Required: no exit from WAIT_LOCK, because the stability counter restarts each time. At 200 cycles after WAIT_CAL entry: lock_timeout pulses once, retry_cnt=1, pll_powerdown=1.
3. Retry saturation: locked held 0 for 5 timeout rounds. Required: retry_cnt goes 1, 2, 3, 3, 3 and lock_timeout pulses 5 times.
4. Loss-of-lock filter in READY: a 2-cycle locked drop leaves tx_clk_ready=1. A 3-cycle drop gives tx_clk_ready=0 and pll_powerdown=1 on the 3rd synced-low cycle, with retry_cnt unchanged.
5. Unlock during MCGB_RST: drop locked in the 2nd MCGB_RST cycle. Required: PWRDN is entered and tx_clk_ready never asserts.
6. restart_req and async reset mid-sequence: restart_req in WAIT_LOCK gives PWRDN with a full 10-cycle powerdown. rst_n=0 in READY immediately forces every output to its reset value, independent of clk.

Source files
------------

// File: rtl/atx_pll_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : atx_pll_rst_seq
// Brief    : Power-up / reset sequencer for the ATX TX PLL and master CGB.
//            Drives PLL powerdown and CGB reset, qualifies a stable lock and
//            re-sequences on lock timeout, loss of lock or software restart.
// Revision : 1.0 - initial release
// ============================================================================
module atx_pll_rst_seq #(
    parameter int PWRDN_CYC        = 100,
    parameter int CAL_MIN_CYC      = 8,
    parameter int LOCK_STABLE_CYC  = 1000,
    parameter int LOCK_TIMEOUT_CYC = 100000,
    parameter int MCGB_RST_CYC     = 16,
    parameter int LOL_FILT_CYC     = 3,
    parameter int RETRY_W          = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               restart_req,
    input  logic               pll_locked,
    input  logic               pll_cal_busy,
    output logic               pll_powerdown,
    output logic               mcgb_rst,
    output logic               tx_clk_ready,
    output logic               lock_timeout,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [2:0]         fsm_state
);

    typedef enum logic [2:0] {
        S_PWRDN     = 3'd0,
        S_WAIT_CAL  = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_MCGB_RST  = 3'd3,
        S_READY     = 3'd4
    } state_t;

    // Zero-cycle settings are treated as one cycle so terminal values stay valid
    localparam int c_PWRDN_N = (PWRDN_CYC        > 0) ? PWRDN_CYC        : 1;
    localparam int c_CAL_N   = (CAL_MIN_CYC      > 0) ? CAL_MIN_CYC      : 1;
    localparam int c_STAB_N  = (LOCK_STABLE_CYC  > 0) ? LOCK_STABLE_CYC  : 1;
    localparam int c_TO_N    = (LOCK_TIMEOUT_CYC > 0) ? LOCK_TIMEOUT_CYC : 1;
    localparam int c_MCGB_N  = (MCGB_RST_CYC     > 0) ? MCGB_RST_CYC     : 1;
    localparam int c_LOL_N   = (LOL_FILT_CYC     > 0) ? LOL_FILT_CYC     : 1;

    localparam int c_MAX_0 = (c_PWRDN_N > c_CAL_N)  ? c_PWRDN_N : c_CAL_N;
    localparam int c_MAX_1 = (c_MAX_0   > c_STAB_N) ? c_MAX_0   : c_STAB_N;
    localparam int c_MAX_2 = (c_MAX_1   > c_TO_N)   ? c_MAX_1   : c_TO_N;
    localparam int c_MAX_3 = (c_MAX_2   > c_MCGB_N) ? c_MAX_2   : c_MCGB_N;
    localparam int c_MAX   = (c_MAX_3   > c_LOL_N)  ? c_MAX_3   : c_LOL_N;
    localparam int c_TW    = $clog2(c_MAX) + 1;

    // Counters hold "cycles already spent"; the transition fires at N-1
    localparam logic [c_TW-1:0] c_PWRDN_LAST = c_TW'(c_PWRDN_N - 1);
    localparam logic [c_TW-1:0] c_CAL_LAST   = c_TW'(c_CAL_N - 1);
    localparam logic [c_TW-1:0] c_STAB_LAST  = c_TW'(c_STAB_N - 1);
    localparam logic [c_TW-1:0] c_TO_LAST    = c_TW'(c_TO_N - 1);
    localparam logic [c_TW-1:0] c_MCGB_LAST  = c_TW'(c_MCGB_N - 1);
    localparam logic [c_TW-1:0] c_LOL_LAST   = c_TW'(c_LOL_N - 1);

    state_t            r_state;
    logic [c_TW-1:0]   r_dwell;
    logic [c_TW-1:0]   r_to_cnt;
    logic [c_TW-1:0]   r_stab;
    logic [c_TW-1:0]   r_lol;
    logic              r_lock_meta;
    logic              r_lock_s;
    logic              r_cal_meta;
    logic              r_cal_s;

    state_t            w_next;
    logic              w_timeout;
    logic              w_to_hit;
    logic              w_stay;
    logic              w_tmo_keep;
    logic [c_TW-1:0]   w_dwell_cap;

    assign fsm_state  = r_state;
    assign w_to_hit   = (r_to_cnt == c_TO_LAST);
    assign w_stay     = !restart_req && (w_next == r_state);
    assign w_tmo_keep = ((r_state == S_WAIT_CAL) || (r_state == S_WAIT_LOCK)) &&
                        ((w_next  == S_WAIT_CAL) || (w_next  == S_WAIT_LOCK));

    // Two-flop synchronizers for the asynchronous PLL status inputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock_meta <= 1'b0;
            r_lock_s    <= 1'b0;
            r_cal_meta  <= 1'b0;
            r_cal_s     <= 1'b0;
        end else begin
            r_lock_meta <= pll_locked;
            r_lock_s    <= r_lock_meta;
            r_cal_meta  <= pll_cal_busy;
            r_cal_s     <= r_cal_meta;
        end
    end

    // Next-state decision; restart wins, then timeout, then normal progress
    always_comb begin
        w_next      = S_PWRDN;
        w_timeout   = 1'b0;
        w_dwell_cap = '0;
        if (restart_req) begin
            w_next = S_PWRDN;
        end else begin
            case (r_state)
                S_PWRDN: begin
                    w_dwell_cap = c_PWRDN_LAST;
                    w_next      = (r_dwell == c_PWRDN_LAST) ? S_WAIT_CAL : S_PWRDN;
                end
                S_WAIT_CAL: begin
                    w_dwell_cap = c_CAL_LAST;
                    if (w_to_hit) begin
                        w_next    = S_PWRDN;
                        w_timeout = 1'b1;
                    end else if ((r_dwell == c_CAL_LAST) && !r_cal_s) begin
                        w_next = S_WAIT_LOCK;
                    end else begin
                        w_next = S_WAIT_CAL;
                    end
                end
                S_WAIT_LOCK: begin
                    if (w_to_hit) begin
                        w_next    = S_PWRDN;
                        w_timeout = 1'b1;
                    end else if (r_lock_s && (r_stab == c_STAB_LAST)) begin
                        w_next = S_MCGB_RST;
                    end else begin
                        w_next = S_WAIT_LOCK;
                    end
                end
                S_MCGB_RST: begin
                    w_dwell_cap = c_MCGB_LAST;
                    if (!r_lock_s) begin
                        w_next = S_PWRDN;
                    end else if (r_dwell == c_MCGB_LAST) begin
                        w_next = S_READY;
                    end else begin
                        w_next = S_MCGB_RST;
                    end
                end
                S_READY: begin
                    w_next = (!r_lock_s && (r_lol == c_LOL_LAST)) ? S_PWRDN : S_READY;
                end
                default: begin
                    w_next = S_PWRDN;
                end
            endcase
        end
    end

    // State, timers and outputs registered together from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_PWRDN;
            r_dwell       <= '0;
            r_to_cnt      <= '0;
            r_stab        <= '0;
            r_lol         <= '0;
            pll_powerdown <= 1'b1;
            mcgb_rst      <= 1'b1;
            tx_clk_ready  <= 1'b0;
            lock_timeout  <= 1'b0;
            retry_cnt     <= '0;
        end else begin
            r_state <= w_next;

            // Per-state dwell; saturates at the state's terminal value
            if (!w_stay) begin
                r_dwell <= '0;
            end else if (r_dwell != w_dwell_cap) begin
                r_dwell <= r_dwell + 1'b1;
            end

            // Timeout spans WAIT_CAL and WAIT_LOCK as one window
            r_to_cnt <= w_tmo_keep ? (r_to_cnt + 1'b1) : '0;

            // Run of synced-locked cycles inside WAIT_LOCK
            r_stab <= (w_stay && (r_state == S_WAIT_LOCK) && r_lock_s) ?
                      (r_stab + 1'b1) : '0;

            // Run of synced-unlocked cycles inside READY
            r_lol <= (w_stay && (r_state == S_READY) && !r_lock_s) ?
                     (r_lol + 1'b1) : '0;

            pll_powerdown <= (w_next == S_PWRDN);
            mcgb_rst      <= (w_next != S_READY);
            tx_clk_ready  <= (w_next == S_READY);
            lock_timeout  <= w_timeout;

            if (w_timeout && (retry_cnt != {RETRY_W{1'b1}})) begin
                retry_cnt <= retry_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_atx_pll_rst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_atx_pll_rst_seq
// Brief    : Self-checking bench for atx_pll_rst_seq with a timestamp-based
//            reference model and directed scenario checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_atx_pll_rst_seq;

    localparam int PWRDN_CYC        = 10;
    localparam int CAL_MIN_CYC      = 8;
    localparam int LOCK_STABLE_CYC  = 20;
    localparam int LOCK_TIMEOUT_CYC = 200;
    localparam int MCGB_RST_CYC     = 4;
    localparam int LOL_FILT_CYC     = 3;
    localparam int RETRY_W          = 2;
    localparam int RETRY_MAX        = (1 << RETRY_W) - 1;

    logic               clk          = 1'b0;
    logic               rst_n        = 1'b0;
    logic               restart_req  = 1'b0;
    logic               pll_locked   = 1'b0;
    logic               pll_cal_busy = 1'b0;
    logic               pll_powerdown;
    logic               mcgb_rst;
    logic               tx_clk_ready;
    logic               lock_timeout;
    logic [RETRY_W-1:0] retry_cnt;
    logic [2:0]         fsm_state;

    atx_pll_rst_seq #(
        .PWRDN_CYC        (PWRDN_CYC),
        .CAL_MIN_CYC      (CAL_MIN_CYC),
        .LOCK_STABLE_CYC  (LOCK_STABLE_CYC),
        .LOCK_TIMEOUT_CYC (LOCK_TIMEOUT_CYC),
        .MCGB_RST_CYC     (MCGB_RST_CYC),
        .LOL_FILT_CYC     (LOL_FILT_CYC),
        .RETRY_W          (RETRY_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .restart_req   (restart_req),
        .pll_locked    (pll_locked),
        .pll_cal_busy  (pll_cal_busy),
        .pll_powerdown (pll_powerdown),
        .mcgb_rst      (mcgb_rst),
        .tx_clk_ready  (tx_clk_ready),
        .lock_timeout  (lock_timeout),
        .retry_cnt     (retry_cnt),
        .fsm_state     (fsm_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    // Reference model: phases by their status codes, progress by timestamps
    int cyc;
    int m_phase;
    int t_enter;
    int t_cal;
    int base_lock;
    int base_lol;
    int m_retry;
    bit m_pd, m_mr, m_rdy, m_to;
    bit lk_hist[$];
    bit cb_hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        cyc = 0; m_phase = 0; t_enter = 0; t_cal = 0;
        base_lock = 0; base_lol = 0; m_retry = 0;
        m_pd = 1'b1; m_mr = 1'b1; m_rdy = 1'b0; m_to = 1'b0;
        lk_hist.delete();
        cb_hist.delete();
    endtask

    task automatic model_step();
        int nxt;
        bit ls, cs, to;
        cyc++;
        lk_hist.push_back(pll_locked);
        cb_hist.push_back(pll_cal_busy);
        // Synced view at this edge is what the inputs were two edges ago
        ls  = (cyc >= 3) ? lk_hist[cyc-3] : 1'b0;
        cs  = (cyc >= 3) ? cb_hist[cyc-3] : 1'b0;
        nxt = m_phase;
        to  = 1'b0;
        if (restart_req) nxt = 0;
        else begin
            case (m_phase)
                0: if (cyc - t_enter >= PWRDN_CYC) nxt = 1;
                1, 2: begin
                    if (cyc - t_cal >= LOCK_TIMEOUT_CYC) begin
                        nxt = 0; to = 1'b1;
                    end else if (m_phase == 1) begin
                        if ((cyc - t_enter >= CAL_MIN_CYC) && !cs) nxt = 2;
                    end else if (ls && (cyc - base_lock >= LOCK_STABLE_CYC)) begin
                        nxt = 3;
                    end
                end
                3: begin
                    if (!ls) nxt = 0;
                    else if (cyc - t_enter >= MCGB_RST_CYC) nxt = 4;
                end
                4: if (!ls && (cyc - base_lol >= LOL_FILT_CYC)) nxt = 0;
                default: nxt = 0;
            endcase
        end
        if (m_phase == 2 && !ls) base_lock = cyc;
        if (m_phase == 4 && ls)  base_lol  = cyc;
        if (nxt != m_phase || restart_req) begin
            t_enter = cyc; base_lock = cyc; base_lol = cyc;
            if (nxt == 1) t_cal = cyc;
        end
        if (to && m_retry < RETRY_MAX) m_retry++;
        m_phase = nxt;
        m_pd  = (nxt == 0);
        m_mr  = (nxt != 4);
        m_rdy = (nxt == 4);
        m_to  = to;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("state",  32'(fsm_state),     32'(m_phase));
        chk("pwrdn",  32'(pll_powerdown), 32'(m_pd));
        chk("mcgb",   32'(mcgb_rst),      32'(m_mr));
        chk("ready",  32'(tx_clk_ready),  32'(m_rdy));
        chk("tmo",    32'(lock_timeout),  32'(m_to));
        chk("retry",  32'(retry_cnt),     32'(m_retry));
    endtask

    task automatic wait_state(input int s, input int budget);
        for (int k = 0; k < budget; k++) begin
            if (32'(fsm_state) == s) break;
            tick();
        end
        chk("reach_state", 32'(fsm_state), 32'(s));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_pd"},    32'(pll_powerdown), 32'd1);
        chk({tag, "_mcgb"},  32'(mcgb_rst),      32'd1);
        chk({tag, "_rdy"},   32'(tx_clk_ready),  32'd0);
        chk({tag, "_tmo"},   32'(lock_timeout),  32'd0);
        chk({tag, "_retry"}, 32'(retry_cnt),     32'd0);
        chk({tag, "_state"}, 32'(fsm_state),     32'd0);
    endtask

    int pd_fall, d_edge, l_edge, r0, m_edge, pd_edge, ever_rdy;
    int tc, ofs, pulses, pulse_edge, pd_at_to, saw_mcgb, cnt, exp_r;

    initial begin
        model_reset();
        // Reset state
        #22;
        chk_reset_vals("rst");

        // 1. Nominal bring-up
        pll_cal_busy = 1'b1;
        rst_n        = 1'b1;
        pd_fall      = -1;
        for (int i = 0, n = $urandom_range(25, 40); i < n; i++) begin
            tick();
            if (pd_fall < 0 && !pll_powerdown) pd_fall = cyc;
        end
        chk("t1_pd_fall", pd_fall, PWRDN_CYC);
        pll_cal_busy = 1'b0;
        d_edge = cyc + 1;
        wait_state(2, 20);
        chk("t1_wl_entry", cyc, d_edge + 2);
        for (int i = 0, n = $urandom_range(2, 8); i < n; i++) tick();
        pll_locked = 1'b1;
        l_edge = cyc + 1;
        for (int k = 0; k < 60 && !tx_clk_ready; k++) tick();
        chk("t1_ready_rise", cyc, l_edge + 1 + LOCK_STABLE_CYC + MCGB_RST_CYC);
        chk("t1_mcgb_fall", 32'(mcgb_rst), 32'd0);

        // 4. Loss-of-lock filter in READY
        for (int i = 0, n = $urandom_range(3, 6); i < n; i++) tick();
        pll_locked = 1'b0;
        tick(); tick();
        pll_locked = 1'b1;
        repeat (8) tick();
        chk("t4_glitch_rdy", 32'(tx_clk_ready), 32'd1);
        r0 = int'(retry_cnt);
        pll_locked = 1'b0;
        d_edge = cyc + 1;
        tick(); tick(); tick();
        pll_locked = 1'b1;
        for (int k = 0; k < 10 && !pll_powerdown; k++) tick();
        chk("t4_lol_edge", cyc, d_edge + 4);
        chk("t4_lol_rdy", 32'(tx_clk_ready), 32'd0);
        chk("t4_lol_retry", 32'(retry_cnt), 32'(r0));

        // 5. Unlock during MCGB_RST
        wait_state(2, 100);
        repeat (LOCK_STABLE_CYC - 1) tick();
        pll_locked = 1'b0;
        tick();
        chk("t5_mcgb_entry", 32'(fsm_state), 32'd3);
        m_edge   = cyc;
        pd_edge  = -1;
        ever_rdy = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (tx_clk_ready) ever_rdy = 1;
            if (pd_edge < 0 && fsm_state == 3'd0) pd_edge = cyc;
        end
        chk("t5_pd_edge", pd_edge, m_edge + 2);
        chk("t5_never_rdy", ever_rdy, 0);
        chk("t5_pd", 32'(pll_powerdown), 32'd1);

        // 2. Lock chatter until timeout
        wait_state(1, 20);
        tc = cyc;
        ofs = $urandom_range(0, 14);
        pulses = 0; pulse_edge = -1; pd_at_to = -1; saw_mcgb = 0;
        while (cyc < tc + LOCK_TIMEOUT_CYC + 5) begin
            pll_locked = (((cyc + 1 - tc) % 15) != ofs);
            tick();
            if (fsm_state == 3'd3) saw_mcgb = 1;
            if (lock_timeout) begin
                pulses++;
                pulse_edge = cyc;
                pd_at_to   = int'(pll_powerdown);
            end
        end
        chk("t2_pulses", pulses, 1);
        chk("t2_pulse_edge", pulse_edge, tc + LOCK_TIMEOUT_CYC);
        chk("t2_pd", pd_at_to, 1);
        chk("t2_retry", 32'(retry_cnt), 32'd1);
        chk("t2_no_exit", saw_mcgb, 0);

        // 6a. restart_req in WAIT_LOCK gives a full powerdown
        pll_locked = 1'b1;
        wait_state(2, 60);
        for (int i = 0, n = $urandom_range(1, 10); i < n; i++) tick();
        restart_req = 1'b1;
        tick();
        restart_req = 1'b0;
        chk("t6_restart_state", 32'(fsm_state), 32'd0);
        cnt = pll_powerdown ? 1 : 0;
        for (int k = 0; k < 30 && pll_powerdown; k++) begin
            tick();
            if (pll_powerdown) cnt++;
        end
        chk("t6_pd_len", cnt, PWRDN_CYC);

        // 6b. Asynchronous reset while READY
        for (int k = 0; k < 100 && !tx_clk_ready; k++) tick();
        chk("t6_ready", 32'(tx_clk_ready), 32'd1);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_vals("arst");
        pll_locked = 1'b0;
        model_reset();
        #20;
        chk_reset_vals("arst_hold");
        rst_n = 1'b1;

        // 3. Retry saturation with lock never arriving
        pulses = 0;
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 260; k++) begin
                tick();
                if (lock_timeout) break;
            end
            if (lock_timeout) pulses++;
            exp_r = (r + 1 > RETRY_MAX) ? RETRY_MAX : r + 1;
            chk("t3_pulse", 32'(lock_timeout), 32'd1);
            chk("t3_retry", 32'(retry_cnt), 32'(exp_r));
        end
        chk("t3_pulses", pulses, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
